// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared opcode/immediate types, I-mem size and inst-writer state
package rvc_asap_pkg;
  localparam logic [31:0] I_MEM_MSB = 32'h0000_0FFF;
  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    I_OP   = 7'b0010011,
    R_OP   = 7'b0110011,
    FENCE  = 7'b0001111,
    SYSCAL = 7'b1110011
  } t_opcode;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} t_immediate;
  typedef enum logic [1:0] {IDLE, RUN, FULL} t_inst_writer_state;
  function automatic t_immediate imm_type(input logic [6:0] op);
    case (op)
      LUI, AUIPC:                    return IMM_U;
      JAL:                           return IMM_J;
      JALR, LOAD, I_OP, FENCE, SYSCAL: return IMM_I;
      BRANCH:                        return IMM_B;
      STORE:                         return IMM_S;
      default:                       return IMM_NONE;
    endcase
  endfunction
  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, I_OP, R_OP, FENCE, SYSCAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/rvc_asap_inst_encode.sv
// rvc_asap_inst_encode: combinational descriptor to RV32I instruction word
module rvc_asap_inst_encode
  import rvc_asap_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);
  t_immediate it;
  logic shamt;
  always_comb begin
    it = imm_type(opcode);
    legal = opcode_legal(opcode);
    // SLLI/SRLI/SRAI carry funct7 in the upper immediate bits
    shamt = opcode == I_OP && funct3[1:0] == 2'b01;
    word = it == IMM_U ? {imm[31:12], rd, opcode}
         : it == IMM_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
         : it == IMM_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
         : it == IMM_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
         : it == IMM_I ? (shamt ? {funct7, imm[4:0], rs1, funct3, rd, opcode}
                                : {imm[11:0], rs1, funct3, rd, opcode})
         : {funct7, rs2, rs1, funct3, rd, opcode};
  end
endmodule

// File: rtl/rvc_asap_inst_writer.sv
// rvc_asap_inst_writer: encodes instruction descriptors and writes them to consecutive I-mem words
module rvc_asap_inst_writer
  import rvc_asap_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] MEM_MSB   = I_MEM_MSB
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        Start,
  input  logic        InValid,
  output logic        InReady,
  input  logic [6:0]  InOpcode,
  input  logic [4:0]  InRd,
  input  logic [4:0]  InRs1,
  input  logic [4:0]  InRs2,
  input  logic [2:0]  InFunct3,
  input  logic [6:0]  InFunct7,
  input  logic [31:0] InImm,
  output logic        MemWrEn,
  output logic [31:0] MemWrAddr,
  output logic [31:0] MemWrData,
  output logic        Full,
  output logic        IllegalOp,
  output logic [10:0] InstCount
);
  t_inst_writer_state state, state_nxt;
  logic [31:0] addr, word;
  logic legal, accept, write;
  rvc_asap_inst_encode u_enc (
    .opcode(InOpcode),
    .rd(InRd),
    .rs1(InRs1),
    .rs2(InRs2),
    .funct3(InFunct3),
    .funct7(InFunct7),
    .imm(InImm),
    .word(word),
    .legal(legal)
  );
  always_comb begin
    InReady = state == RUN && !Start;
    Full = state == FULL;
    accept = InValid && InReady;
    write = accept && legal;
    state_nxt = Start ? RUN : write && addr == MEM_MSB - 32'd3 ? FULL : state;
  end
  always_ff @(posedge Clock or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge Clock or posedge Rst)
    if (Rst) begin
      addr <= BASE_ADDR;
      InstCount <= '0;
      IllegalOp <= 1'b0;
      MemWrEn <= 1'b0;
      MemWrAddr <= '0;
      MemWrData <= '0;
    end else begin
      MemWrEn <= write;
      if (Start) begin
        addr <= BASE_ADDR;
        InstCount <= '0;
        IllegalOp <= 1'b0;
      end else if (accept && !legal) IllegalOp <= 1'b1;
      else if (write) begin
        addr <= addr + 32'd4;
        InstCount <= InstCount + 11'd1;
        MemWrAddr <= addr;
        MemWrData <= word;
      end
    end
endmodule

// File: doc/rvc_asap_inst_writer.md
Name: rvc_asap_inst_writer

Overview:
- Write-side counterpart of the core's instruction fetch/decode path.
- Accepts decoded instruction descriptors (opcode, register indices, funct fields, full 32-bit immediate), encodes each into a 32-bit RV32I instruction word, and writes it into instruction memory at consecutive word addresses.
- Used by the bench and the boot loader to fill I-mem before the core runs.
- Memory side is a simple registered write port.

Parameters:
- BASE_ADDR, 32'h0, byte address of the first word written; word-aligned.
- MEM_MSB, I_MEM_MSB, last byte address of I-mem; the last writable word is MEM_MSB-3.

Ports:
- Clock  in  1  single clock; all state on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Start  in  1  pulse: reset the address to BASE_ADDR, clear the count and flags, enter RUN.
- InValid  in  1  descriptor valid.
- InReady  out  1  writer accepts a descriptor this cycle.
- InOpcode  in  7  t_opcode.
- InRd  in  5  destination register.
- InRs1  in  5  source register 1.
- InRs2  in  5  source register 2.
- InFunct3  in  3  funct3, or t_branch_type for BRANCH.
- InFunct7  in  7  funct7; R_OP, and shift-immediate I_OP.
- InImm  in  32  immediate, already sign-extended/positioned; U-type uses InImm[31:12].
- MemWrEn  out  1  write strobe.
- MemWrAddr  out  32  byte address.
- MemWrData  out  32  encoded instruction.
- Full  out  1  last word written; state FULL.
- IllegalOp  out  1  sticky: an opcode outside t_opcode was seen.
- InstCount  out  11  number of words written since Start.

Behaviour:
- Reset (async, Rst=1) values:
  - state=IDLE
  - MemWrEn=0, MemWrAddr=0, MemWrData=0
  - Full=0, IllegalOp=0, InstCount=0
  - internal address = BASE_ADDR
  - any in-flight write is dropped.
- States:
  - IDLE: InReady=0. Start -> RUN.
  - RUN: InReady = !Start.
  - FULL: InReady=0, Full=1. Start -> RUN.
- Start in any state: address <= BASE_ADDR, InstCount <= 0, Full <= 0, IllegalOp <= 0. A descriptor presented the same cycle is not accepted, because InReady=0.
- Accept = InValid & InReady. Data is held only by the producer; the writer does not buffer.
- Latency: MemWrEn/Addr/Data are registered outputs. On an accept at edge N they are valid for exactly the cycle after edge N. MemWrEn=1 lasts one cycle per accept; back-to-back accepts produce back-to-back writes.
- After each legal accept: address += 4 and InstCount += 1.
- Accept at address == MEM_MSB-3: the write is issued, then state -> FULL. The address does not wrap.
- Immediate type derived from the opcode (t_immediate):
  - LUI, AUIPC: U
  - JAL: J
  - JALR, LOAD, I_OP, FENCE, SYSCAL: I
  - BRANCH: B
  - STORE: S
  - R_OP: none
- Encoding, with op = opcode, f3 = InFunct3, f7 = InFunct7, i = InImm:
  - R: f7 | rs2 | rs1 | f3 | rd | op
  - I: i[11:0] | rs1 | f3 | rd | op
    - I_OP with f3 = 001 or 101: bits[31:25] = f7, bits[24:20] = i[4:0].
  - S: i[11:5] | rs2 | rs1 | f3 | i[4:0] | op
  - B: i[12] | i[10:5] | rs2 | rs1 | f3 | i[4:1] | i[11] | op
  - U: i[31:12] | rd | op
  - J: i[20] | i[10:1] | i[11] | i[19:12] | rd | op
- Unused immediate bits are ignored. i[0] of B/J is not checked.
- Illegal opcode (not a t_opcode member):
  - the descriptor is consumed
  - no write; address and count are unchanged
  - IllegalOp <= 1, sticky until Start or Rst.
- Rst asserted mid-write: MemWrEn drops asynchronously.

Decomposition:
- rvc_asap_pkg gets the following additions:
  - t_inst_writer_state enum (IDLE, RUN, FULL).
  - Opcode-to-t_immediate mapping as a package function.
  - Existing t_opcode, t_immediate and I_MEM_MSB are reused.
- Sub-module rvc_asap_inst_encode: combinational descriptor -> {word, legal}. It is reusable by the bench's reference model.
- The top holds the FSM, address/count registers and output registers.

Test Plan:
- Rst, Start, then ADDI x1,x0,5 (op 0x13, rd 1, f3 0, imm 5) -> one cycle later MemWrEn=1, Addr=0x0, Data=0x00500093, InstCount=1.
- Back-to-back descriptors, each written on consecutive cycles at addresses 0x4, 0x8, 0xC, 0x10:
  - LUI x2, imm 0x12345000 -> 0x12345137
  - BEQ x1,x2,+8 -> 0x00208463
  - SW x5,12(x2) -> 0x00512623
  - JAL x1,+16 -> 0x010000EF
- SRAI x3,x1,4 (f3 101, f7 0x20, imm 4) -> 0x4040D193. InValid toggled randomly: exactly one write per accept.
- MEM_MSB='h1F: write 8 descriptors -> the 8th goes to Addr 0x1C, then Full=1, InReady=0. A 9th InValid is not accepted. Start -> Full=0, next write at 0x0, InstCount=1.
- Opcode 7'h7F accepted -> no MemWrEn, IllegalOp=1, address unchanged. The next legal descriptor is written at the unchanged address.
- Start and InValid asserted together -> descriptor not accepted. Rst asserted during the write cycle -> MemWrEn=0 immediately; after release, state=IDLE and InReady=0.
